led_sequence_ctrl: RTL and testbench
====================================

Name: led_sequence_ctrl

Overview:
- Controller and sequencer for the 8-LED bank on the lab board.
- Generates a programmable step tick from the system clock and drives a selectable LED pattern each tick: rotate, bounce, fill/drain or blink.
- Accepts mode, speed, direction, pause and load controls from the board's switches and debounced buttons.
- Sits between the user-input logic and the LED pins, replacing free-running fixed-pattern LED logic.

Parameters:
- TICK_DIV, 50000000, clock cycles per step at speed 0 (1 s at 50 MHz); must be ≥ 8.
- CNT_W, 27, width of the tick counter; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  pattern select: 00 ROTATE, 01 BOUNCE, 10 FILL, 11 BLINK.
- dir  in  1  ROTATE direction: 0 toward MSB, 1 toward LSB.
- speed  in  2  step period = TICK_DIV >> speed cycles.
- pause  in  1  level; 1 freezes counter and pattern.
- load  in  1  single-cycle pulse; loads load_val (ROTATE only).
- load_val  in  8  pattern to load.
- led  out  8  LED drive, registered.
- step_pulse  out  1  one-cycle strobe on every pattern step.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=ROT, mode_q=00, led=0x01, counter=0, step_pulse=0.
- Internal registers:
  - mode_q: last accepted mode.
  - counter: CNT_W bits.
  - state: one of ROT, BNC_UP, BNC_DN, FILL, DRAIN, BLINK.
- Period and terminal condition:
  - period = TICK_DIV >> speed.
  - Terminal when counter ≥ period-1. The ≥ compare covers a speed increase mid-count: the step fires on the next cycle.
- Per-edge priority, highest first:
  1. Mode change (mode≠mode_q): mode_q<=mode, counter<=0, step_pulse<=0, state/led<=seed of new mode. Seeds: ROTATE→ROT/0x01; BOUNCE→BNC_UP/0x01; FILL→FILL/0x00; BLINK→BLINK/0xFF.
  2. load=1 while state=ROT: led<=load_val, counter<=0, step_pulse<=0. load is ignored in all other states.
  3. pause=1: counter, led and state hold; step_pulse<=0.
  4. Terminal: counter<=0, step_pulse<=1, and led/state advance on the same edge.
  5. Otherwise: counter<=counter+1, step_pulse<=0.
- Latency: first step occurs at the period-th rising edge after reset release, mode change or load. step_pulse is high for the cycle in which the new led value is visible.
- Step rules:
  - ROT, dir=0: led<={led[6:0],led[7]}.
  - ROT, dir=1: led<={led[0],led[7:1]}.
  - dir is sampled at each step; a change takes effect at the next step with no reseed.
  - ROT with led=0x00 stays 0x00 and step_pulse still fires. Patterns with multiple bits set rotate intact.
  - BNC_UP: led<=led<<1; go to BNC_DN if the new led=0x80.
  - BNC_DN: led<=led>>1; go to BNC_UP if the new led=0x01.
  - Bounce sequence: 01,02,…,80,40,…,01,02; no repeated endpoints.
  - FILL: led<={led[6:0],1'b1}; go to DRAIN if the new led=0xFF.
  - DRAIN: led<={led[6:0],1'b0}; go to FILL if the new led=0x00.
  - BLINK: led<=~led.
  - dir, speed and load_val do not affect BOUNCE, FILL or BLINK.
- Reset mid-step or mid-pause: immediate return to reset values; pause has no memory.
- Illegal or unreachable state encodings recover to ROT with led=0x01 on the next edge.

Test Plan (TICK_DIV=8 unless noted):
1. Reset, mode=00, dir=0, speed=0, run 24 cycles → step_pulse at cycles 8, 16, 24; led 0x02, 0x04, 0x08. Assert rst_n=0 mid-count → led=0x01 and counter=0 immediately, without waiting for a clock edge.
2. mode=01, 16 steps → led sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. mode=10, 17 steps → 01,03,…,FF,FE,FC,…,80,00,01.
3. mode=00, load pulse with load_val=0x81 → led=0x81. Then dir=1, 2 steps → 0xC0, 0x60. Load pulse in mode=11 → led unchanged.
4. speed=3 (period 1) → step_pulse high every cycle. Set speed=0 with counter at 5, then switch speed=2 (period 2) → step on the next edge, then every 2 cycles.
5. pause=1 for 20 cycles mid-count → led, counter and step_pulse frozen/low. Release → remaining count completes, then step. Switch mode 00→11 while paused → led=0xFF at once, counter=0; with pause released, toggles to 0x00 after 8 cycles.
6. mode change and load on the same edge → the mode seed wins and load is ignored. Load on a terminal edge → led=load_val, no step_pulse.

Source files
------------

// File: rtl/led_sequence_ctrl.sv
// Eight-LED pattern sequencer: programmable step tick driving rotate, bounce,
// fill/drain and blink patterns, with pause, load and live speed/direction.
module led_sequence_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       dir,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] led,
  output logic       step_pulse
);

  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  localparam logic [2:0] ST_ROT    = 3'd0;
  localparam logic [2:0] ST_BNC_UP = 3'd1;
  localparam logic [2:0] ST_BNC_DN = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_BLINK  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       led_q, led_d;
  logic             step_q, step_d;

  logic [31:0]      period;
  logic             terminal;
  logic [2:0]       seed_state, step_state;
  logic [7:0]       seed_led, step_led;

  // >= rather than == so a mid-count speed increase steps on the next edge
  assign period   = TICK_DIV >> speed;
  assign terminal = (32'(cnt_q) >= (period - 32'd1));

  always_comb begin
    seed_state = ST_BLINK;
    seed_led   = 8'hFF;
    case (mode)
      MODE_ROTATE: begin seed_state = ST_ROT;    seed_led = 8'h01; end
      MODE_BOUNCE: begin seed_state = ST_BNC_UP; seed_led = 8'h01; end
      MODE_FILL:   begin seed_state = ST_FILL;   seed_led = 8'h00; end
      default:     begin seed_state = ST_BLINK;  seed_led = 8'hFF; end
    endcase
  end

  always_comb begin
    step_state = state_q;
    step_led   = led_q;
    case (state_q)
      ST_ROT: begin
        step_led = dir ? {led_q[0], led_q[7:1]} : {led_q[6:0], led_q[7]};
      end
      ST_BNC_UP: begin
        step_led   = led_q << 1;
        step_state = (step_led == 8'h80) ? ST_BNC_DN : ST_BNC_UP;
      end
      ST_BNC_DN: begin
        step_led   = led_q >> 1;
        step_state = (step_led == 8'h01) ? ST_BNC_UP : ST_BNC_DN;
      end
      ST_FILL: begin
        step_led   = {led_q[6:0], 1'b1};
        step_state = (step_led == 8'hFF) ? ST_DRAIN : ST_FILL;
      end
      ST_DRAIN: begin
        step_led   = {led_q[6:0], 1'b0};
        step_state = (step_led == 8'h00) ? ST_FILL : ST_DRAIN;
      end
      ST_BLINK: begin
        step_led = ~led_q;
      end
      default: begin
        step_state = ST_ROT;
        step_led   = 8'h01;
      end
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (mode != mode_q) begin
      mode_d  = mode;
      cnt_d   = '0;
      state_d = seed_state;
      led_d   = seed_led;
    end else if (state_q > ST_BLINK) begin
      state_d = ST_ROT;
      led_d   = 8'h01;
      cnt_d   = '0;
    end else if (load && (state_q == ST_ROT)) begin
      led_d = load_val;
      cnt_d = '0;
    end else if (!pause) begin
      if (terminal) begin
        cnt_d   = '0;
        step_d  = 1'b1;
        state_d = step_state;
        led_d   = step_led;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ROT;
      mode_q  <= MODE_ROTATE;
      cnt_q   <= '0;
      led_q   <= 8'h01;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl with an 8-cycle base step period.
module tb_led_sequence_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       dir;
  logic [1:0] speed;
  logic       pause;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] led;
  logic       step_pulse;

  int errors = 0;
  int checks = 0;

  led_sequence_ctrl #(.TICK_DIV(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .dir(dir), .speed(speed),
    .pause(pause), .load(load), .load_val(load_val),
    .led(led), .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advances until step_pulse is seen or the budget runs out; n is edges used.
  task automatic wait_step(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_pulse && n < max_cycles);
    if (!step_pulse) n = max_cycles + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; dir = 1'b0; speed = 2'd0;
    pause = 1'b0; load = 1'b0; load_val = 8'h00;
    tick(2);
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL reset_led: got %h expected 01", led); end
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step_pulse); end
    rst_n = 1'b1;
  endtask

  task automatic test_rotate();
    logic [7:0] exp_led;
    logic       exp_step;
    int         n;
    exp_led = 8'h01;
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_step = (i % 8 == 0);
      if (exp_step) exp_led = {exp_led[6:0], exp_led[7]};
      checks++;
      if (step_pulse !== exp_step) begin
        errors++; $display("FAIL rot_step cycle %0d: got %b expected %b", i, step_pulse, exp_step);
      end
      checks++;
      if (led !== exp_led) begin
        errors++; $display("FAIL rot_led cycle %0d: got %h expected %h", i, led, exp_led);
      end
    end
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL async_reset_led: got %h expected 01", led); end
    tick();
    rst_n = 1'b1;
    wait_step(20, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL reset_first_step: got %0d edges expected 8", n); end
    checks++;
    if (led !== 8'h02) begin errors++; $display("FAIL reset_first_led: got %h expected 02", led); end
  endtask

  task automatic test_patterns();
    logic [7:0] bnc [15];
    logic [7:0] fil [17];
    int n;
    bnc = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    fil = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
            8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    mode = 2'b01;
    tick();
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL bounce_seed: got %h expected 01", led); end
    for (int i = 0; i < 15; i++) begin
      wait_step(20, n);
      checks++;
      if (n !== 8 || led !== bnc[i]) begin
        errors++; $display("FAIL bounce_step %0d: got %h after %0d edges expected %h after 8", i, led, n, bnc[i]);
      end
    end
    mode = 2'b10;
    tick();
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL fill_seed: got %h expected 00", led); end
    for (int i = 0; i < 17; i++) begin
      wait_step(20, n);
      checks++;
      if (n !== 8 || led !== fil[i]) begin
        errors++; $display("FAIL fill_step %0d: got %h after %0d edges expected %h after 8", i, led, n, fil[i]);
      end
    end
  endtask

  task automatic test_load();
    int n;
    mode = 2'b00; dir = 1'b0;
    tick();
    load = 1'b1; load_val = 8'h81;
    tick();
    load = 1'b0;
    checks++;
    if (led !== 8'h81 || step_pulse !== 1'b0) begin
      errors++; $display("FAIL load_rot: got %h/%b expected 81/0", led, step_pulse);
    end
    dir = 1'b1;
    wait_step(20, n);
    checks++;
    if (n !== 8 || led !== 8'hC0) begin errors++; $display("FAIL load_dir1_step1: got %h after %0d expected C0 after 8", led, n); end
    wait_step(20, n);
    checks++;
    if (n !== 8 || led !== 8'h60) begin errors++; $display("FAIL load_dir1_step2: got %h after %0d expected 60 after 8", led, n); end
    mode = 2'b11;
    tick();
    load = 1'b1; load_val = 8'h5A;
    tick();
    load = 1'b0;
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL load_blink_ignored: got %h expected FF", led); end
  endtask

  task automatic test_speed();
    logic [7:0] exp_led;
    exp_led = 8'hFF;
    speed = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_led = ~exp_led;
      checks++;
      if (step_pulse !== 1'b1 || led !== exp_led) begin
        errors++; $display("FAIL speed3 cycle %0d: got %h/%b expected %h/1", i, led, step_pulse, exp_led);
      end
    end
    speed = 2'd0;
    tick(5);
    checks++;
    if (step_pulse !== 1'b0 || led !== exp_led) begin
      errors++; $display("FAIL speed0_count: got %h/%b expected %h/0", led, step_pulse, exp_led);
    end
    speed = 2'd2;
    tick();
    exp_led = ~exp_led;
    checks++;
    if (step_pulse !== 1'b1 || led !== exp_led) begin
      errors++; $display("FAIL speed_up_immediate: got %h/%b expected %h/1", led, step_pulse, exp_led);
    end
    tick();
    checks++;
    if (step_pulse !== 1'b0) begin errors++; $display("FAIL speed2_gap: got %b expected 0", step_pulse); end
    tick();
    exp_led = ~exp_led;
    checks++;
    if (step_pulse !== 1'b1 || led !== exp_led) begin
      errors++; $display("FAIL speed2_step: got %h/%b expected %h/1", led, step_pulse, exp_led);
    end
    speed = 2'd0;
  endtask

  task automatic test_pause();
    int n;
    int bad;
    mode = 2'b00; dir = 1'b0;
    tick();
    tick(3);
    pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (led !== 8'h01 || step_pulse !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
    pause = 1'b0;
    wait_step(20, n);
    checks++;
    if (n !== 5 || led !== 8'h02) begin errors++; $display("FAIL pause_resume: got %h after %0d expected 02 after 5", led, n); end
    tick(2);
    pause = 1'b1;
    tick(2);
    mode = 2'b11;
    tick();
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL pause_mode_seed: got %h expected FF", led); end
    tick(3);
    checks++;
    if (led !== 8'hFF || step_pulse !== 1'b0) begin
      errors++; $display("FAIL pause_blink_hold: got %h/%b expected FF/0", led, step_pulse);
    end
    pause = 1'b0;
    wait_step(20, n);
    checks++;
    if (n !== 8 || led !== 8'h00) begin errors++; $display("FAIL pause_blink_toggle: got %h after %0d expected 00 after 8", led, n); end
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 2'b00; dir = 1'b0;
    tick();
    mode = 2'b01; load = 1'b1; load_val = 8'h3C;
    tick();
    load = 1'b0;
    checks++;
    if (led !== 8'h01) begin errors++; $display("FAIL mode_beats_load: got %h expected 01", led); end
    mode = 2'b00;
    tick();
    tick(7);
    load = 1'b1; load_val = 8'hA5;
    tick();
    load = 1'b0;
    checks++;
    if (led !== 8'hA5 || step_pulse !== 1'b0) begin
      errors++; $display("FAIL load_on_terminal: got %h/%b expected A5/0", led, step_pulse);
    end
    wait_step(20, n);
    checks++;
    if (n !== 8 || led !== 8'h4B) begin errors++; $display("FAIL after_terminal_load: got %h after %0d expected 4B after 8", led, n); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_patterns();
    test_load();
    test_speed();
    test_pause();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
